// File: rtl/dmem_port_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_port_ctrl
//
// Load/store port controller sitting between the CPU datapath and the 256x16
// synchronous DataMemory. It takes one request at a time over a valid/ready
// handshake and drives the memory's address/data/wren from registers. It also
// absorbs the memory read latency (1 or 2 cycles) and returns a one-cycle
// response pulse carrying read data and an out-of-range flag.
//
// Parameters
//   ADDR_W   request / memory address width
//   DATA_W   data word width
//   DEPTH    number of implemented words; addresses >= DEPTH are out of range
//   MEM_LAT  DataMemory read latency in cycles (1 or 2)
//
// Ports
//   clock       single clock, rising edge
//   reset       asynchronous, active-high
//   req_valid   request present
//   req_ready   controller idle and able to accept a request
//   req_we      1 = write, 0 = read
//   req_addr    word address
//   req_wdata   write data
//   resp_valid  one-cycle response pulse (no backpressure)
//   resp_rdata  read data; 0 for writes and out-of-range requests
//   resp_err    request address was out of range
//   address     to DataMemory address
//   data        to DataMemory data
//   wren        to DataMemory wren (one cycle per in-range write)
//   q           from DataMemory q
//
// Build option
//   DMEM_PORT_FWD_EN  when defined, adds a one-entry store-forward buffer that
//                     returns the last in-range write's data to a matching
//                     read without touching the memory.
// ----------------------------------------------------------------------------
module dmem_port_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_nxt;

    logic              accept;
    logic              in_range;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_rdata;

    // Attributes of the accepted request, used while it is in flight.
    logic              we_p1;
    logic              err_p1;
    logic              fwd_p1;

    logic              issue_resp;
    logic              capture_resp;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign in_range  = ({1'b0, req_addr} < DEPTH_LIM);

`ifdef DMEM_PORT_FWD_EN
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fwd_valid <= 1'b0;
        end else if (accept && req_we && in_range) begin
            fwd_valid <= 1'b1;
        end
    end

    // Buffer contents are qualified by fwd_valid, so they need no reset.
    always_ff @(posedge clock) begin
        if (accept && req_we && in_range) begin
            fwd_addr <= req_addr;
            fwd_data <= req_wdata;
        end
    end

    // The range check gates the hit so an out-of-range read reports an error
    // even if its low bits happen to match the buffered address.
    assign fwd_hit   = fwd_valid && in_range && !req_we && (req_addr == fwd_addr);
    assign fwd_rdata = fwd_data;
`else
    assign fwd_hit   = 1'b0;
    assign fwd_rdata = '0;
`endif

    // ---- State register ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- Next state and response strobes ----
    always_comb begin
        state_nxt    = state;
        issue_resp   = 1'b0;
        capture_resp = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                // Writes, errors and forwarded reads need nothing from q.
                if (we_p1 || err_p1 || fwd_p1) begin
                    state_nxt  = IDLE;
                    issue_resp = 1'b1;
                end else if (MEM_LAT == 2) begin
                    state_nxt = WAIT;
                end else begin
                    state_nxt = CAPTURE;
                end
            end
            WAIT: begin
                state_nxt = CAPTURE;
            end
            CAPTURE: begin
                state_nxt    = IDLE;
                capture_resp = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- Request latch (accept cycle -> ISSUE) ----
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            we_p1  <= 1'b0;
            err_p1 <= 1'b0;
            fwd_p1 <= 1'b0;
        end else if (accept) begin
            we_p1  <= req_we;
            err_p1 <= !in_range;
            fwd_p1 <= fwd_hit;
        end
    end

    // ---- Memory-side registers ----
    // wren is loaded only on accept and cleared on every other edge, so it is
    // high exactly for the ISSUE cycle. The asynchronous reset drops it at
    // once, so a write cut off mid-ISSUE never reaches the memory edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            address <= '0;
            data    <= '0;
            wren    <= 1'b0;
        end else begin
            wren <= accept && req_we && in_range;
            if (accept && !fwd_hit) begin
                address <= req_addr;
                data    <= req_wdata;
            end
        end
    end

    // ---- Response registers ----
    // resp_rdata holds between responses so it stays stable through the pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= issue_resp || capture_resp;
            resp_err   <= issue_resp && err_p1;
            if (issue_resp) begin
                resp_rdata <= fwd_p1 ? fwd_rdata : '0;
            end else if (capture_resp) begin
                resp_rdata <= q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_port_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_port_ctrl
//
// Table-driven bench for dmem_port_ctrl with a small behavioural DataMemory
// model (256x16, synchronous read with MEM_LAT cycles of latency). Each table
// record is one request with its expected error flag, read data, response
// latency and whether the memory address/data registers should be reloaded.
// A hand-written sequence covers reset arriving in the ISSUE cycle of a write.
// ----------------------------------------------------------------------------
module tb_dmem_port_ctrl;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int DEPTH   = 256;
    localparam int MEM_LAT = 1;

`ifdef DMEM_PORT_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int RD_LAT  = 2 + MEM_LAT;
    localparam int FWD_LAT = FWD ? 2 : RD_LAT;

    logic              clock;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              wren;
    logic [DATA_W-1:0] q;

    dmem_port_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .MEM_LAT(MEM_LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .address   (address),
        .data      (data),
        .wren      (wren),
        .q         (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioural DataMemory: preloaded with 0xC000 | index.
    logic              mem_load;
    logic [DATA_W-1:0] mem [256];
    logic [DATA_W-1:0] q_d1;
    logic [DATA_W-1:0] q_d2;

    always @(posedge clock) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hC000 | 16'(i);
        end else if (wren) begin
            mem[address[7:0]] <= data;
        end
        q_d1 <= mem[address[7:0]];
        q_d2 <= q_d1;
    end
    assign q = (MEM_LAT == 2) ? q_d2 : q_d1;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_err;
        logic [15:0] exp_rdata;
        int          exp_lat;
        logic        exp_upd;
        logic        hold;
    } vec_t;

    vec_t        vecs [$];
    int          n_chk;
    int          n_fail;
    logic [15:0] exp_address;
    logic [15:0] exp_data;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       input logic err, input logic [15:0] rd, input int lat,
                       input logic upd, input logic hold);
        vec_t v;
        v.we = we; v.addr = addr; v.wdata = wd; v.exp_err = err;
        v.exp_rdata = rd; v.exp_lat = lat; v.exp_upd = upd; v.hold = hold;
        vecs.push_back(v);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, " req_ready"},  32'(req_ready),  32'd1);
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, " resp_rdata"}, 32'(resp_rdata), 32'd0);
        chk({tag, " resp_err"},   32'(resp_err),   32'd0);
        chk({tag, " address"},    32'(address),    32'd0);
        chk({tag, " data"},       32'(data),       32'd0);
        chk({tag, " wren"},       32'(wren),       32'd0);
    endtask

    // Called #1 after an edge with the controller expected to be ready.
    // Returns in the response cycle (where a new request may be presented).
    task automatic do_txn(input string tag, input vec_t v);
        int lat;
        chk({tag, " ready@N"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        step();
        if (!v.hold) req_valid = 1'b0;
        lat = 1;
        if (v.exp_upd) begin
            exp_address = v.addr;
            exp_data    = v.wdata;
        end
        chk({tag, " wren@N+1"},    32'(wren),       32'(v.we && !v.exp_err));
        chk({tag, " address@N+1"}, 32'(address),    32'(exp_address));
        chk({tag, " data@N+1"},    32'(data),       32'(exp_data));
        chk({tag, " ready@N+1"},   32'(req_ready),  32'd0);
        chk({tag, " rvalid@N+1"},  32'(resp_valid), 32'd0);
        while (lat < 8) begin
            step();
            lat++;
            chk({tag, " wren_low"}, 32'(wren), 32'd0);
            if (resp_valid) break;
            chk({tag, " ready_low"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        if (!resp_valid) lat = 99;
        chk({tag, " latency"},    32'(lat),        32'(v.exp_lat));
        chk({tag, " resp_err"},   32'(resp_err),   32'(v.exp_err));
        chk({tag, " resp_rdata"}, 32'(resp_rdata), 32'(v.exp_rdata));
        chk({tag, " ready@resp"}, 32'(req_ready),  32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;
        n_chk       = 0;
        n_fail      = 0;
        exp_address = '0;
        exp_data    = '0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_wdata   = '0;
        mem_load    = 1'b1;
        reset       = 1'b1;

        //   we    addr       wdata      err   rdata      lat      upd   hold
        add(1'b1, 16'd76,    16'h000A, 1'b0, 16'h0000, 2,       1'b1, 1'b0);
        add(1'b0, 16'd76,    16'h0000, 1'b0, 16'h000A, FWD_LAT, !FWD, 1'b0);
        add(1'b1, 16'd76,    16'h000B, 1'b0, 16'h0000, 2,       1'b1, 1'b0);
        add(1'b0, 16'd76,    16'h0000, 1'b0, 16'h000B, FWD_LAT, !FWD, 1'b1);
        add(1'b1, 16'd300,   16'hFFFF, 1'b1, 16'h0000, 2,       1'b1, 1'b0);
        add(1'b0, 16'd76,    16'h0000, 1'b0, 16'h000B, FWD_LAT, !FWD, 1'b0);
        add(1'b0, 16'd300,   16'h0000, 1'b1, 16'h0000, 2,       1'b1, 1'b0);
        add(1'b0, 16'hFFFF,  16'h0000, 1'b1, 16'h0000, 2,       1'b1, 1'b0);
        add(1'b1, 16'd255,   16'h55AA, 1'b0, 16'h0000, 2,       1'b1, 1'b0);
        add(1'b0, 16'd256,   16'h0000, 1'b1, 16'h0000, 2,       1'b1, 1'b0);
        add(1'b0, 16'd255,   16'h0000, 1'b0, 16'h55AA, FWD_LAT, !FWD, 1'b0);
        add(1'b1, 16'd0,     16'h0001, 1'b0, 16'h0000, 2,       1'b1, 1'b0);
        add(1'b0, 16'd255,   16'h0000, 1'b0, 16'h55AA, RD_LAT,  1'b1, 1'b0);
        add(1'b1, 16'd5,     16'h1234, 1'b0, 16'h0000, 2,       1'b1, 1'b0);
        add(1'b0, 16'd5,     16'h0000, 1'b0, 16'h1234, FWD_LAT, !FWD, 1'b0);
        add(1'b0, 16'd6,     16'h0000, 1'b0, 16'hC006, RD_LAT,  1'b1, 1'b0);

        step();
        step();
        mem_load = 1'b0;
        check_reset_values("in_reset");
        reset = 1'b0;
        step();
        check_reset_values("post_reset");

        for (int i = 0; i < vecs.size(); i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset arriving in the ISSUE cycle of a write of 0x1111 to 76.
        step();
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'd76;
        req_wdata = 16'h1111;
        step();
        req_valid = 1'b0;
        chk("rst_mid wren_before", 32'(wren), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid wren_async", 32'(wren), 32'd0);
        check_reset_values("rst_mid held");
        step();
        check_reset_values("rst_mid edge");
        reset       = 1'b0;
        exp_address = '0;
        exp_data    = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_mid no_resp", 32'(resp_valid), 32'd0);
        end
        check_reset_values("rst_mid after");
        rv.we = 1'b0; rv.addr = 16'd76; rv.wdata = 16'h0000; rv.exp_err = 1'b0;
        rv.exp_rdata = 16'h000B; rv.exp_lat = RD_LAT; rv.exp_upd = 1'b1; rv.hold = 1'b0;
        do_txn("rst_mid read76", rv);

        step();
        chk("final rvalid_clear", 32'(resp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
